// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK modulator.
// Holds the sample and phase widths, the 64-entry signed sine table, the FSM
// state type and small helpers for sign mapping and cosine indexing.
package qpsk_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int LUT_DEPTH = 64;
  localparam int PHASE_W   = 6;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic [PHASE_W-1:0]         phase_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // SIN_LUT[k] = round(2047 * sin(2*pi*k/64)); peak magnitude 2047, so a
  // negated entry always fits and -2048 never appears.
  localparam sample_t SIN_LUT [LUT_DEPTH] = '{
     12'sd0,     12'sd201,   12'sd399,   12'sd594,
     12'sd783,   12'sd965,   12'sd1137,  12'sd1299,
     12'sd1447,  12'sd1582,  12'sd1702,  12'sd1805,
     12'sd1891,  12'sd1959,  12'sd2008,  12'sd2037,
     12'sd2047,  12'sd2037,  12'sd2008,  12'sd1959,
     12'sd1891,  12'sd1805,  12'sd1702,  12'sd1582,
     12'sd1447,  12'sd1299,  12'sd1137,  12'sd965,
     12'sd783,   12'sd594,   12'sd399,   12'sd201,
     12'sd0,    -12'sd201,  -12'sd399,  -12'sd594,
    -12'sd783,  -12'sd965,  -12'sd1137, -12'sd1299,
    -12'sd1447, -12'sd1582, -12'sd1702, -12'sd1805,
    -12'sd1891, -12'sd1959, -12'sd2008, -12'sd2037,
    -12'sd2047, -12'sd2037, -12'sd2008, -12'sd1959,
    -12'sd1891, -12'sd1805, -12'sd1702, -12'sd1582,
    -12'sd1447, -12'sd1299, -12'sd1137, -12'sd965,
    -12'sd783,  -12'sd594,  -12'sd399,  -12'sd201
  };

  // Cosine is the sine table read a quarter cycle (16 entries) ahead.
  function automatic phase_t cos_index(input phase_t phase);
    return phase + 6'd16;
  endfunction

  // Symbol bit 1 selects +carrier, 0 selects -carrier.
  function automatic sample_t apply_sign(input logic sym_bit, input sample_t mag);
    return sym_bit ? mag : -mag;
  endfunction

endpackage

// File: rtl/qpsk_modulator_if.sv
// Symbol-in / sample-out bundle of the QPSK modulator.
// master: symbol producer and sample consumer; slave: the modulator.
interface qpsk_modulator_if;
  import qpsk_pkg::*;

  logic    i_I;
  logic    i_Q;
  logic    i_valid;
  logic    o_ready;
  logic    o_valid;
  sample_t o_I;
  sample_t o_Q;

  modport master (
    output i_I, i_Q, i_valid,
    input  o_ready, o_valid, o_I, o_Q
  );

  modport slave (
    input  i_I, i_Q, i_valid,
    output o_ready, o_valid, o_I, o_Q
  );

endinterface

// File: rtl/qpsk_nco.sv
// Carrier NCO for the QPSK modulator: 6-bit modulo-64 phase accumulator and
// sine/cosine table read at the current phase. The caller decides when the
// phase advances and when it is cleared (QPSK_MOD_CONT_PHASE_EN is resolved
// in the top level, which simply never asserts clear when it is defined).
module qpsk_nco
  import qpsk_pkg::*;
#(
  parameter int PHASE_INC = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    advance,
  input  logic    clear,
  output sample_t cos_val,
  output sample_t sin_val
);

  localparam phase_t PHASE_STEP = phase_t'(PHASE_INC);

  phase_t phase_r;

  // Phase accumulator: clear wins over advance, wraps naturally at 64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 6'd0;
    end else if (clear) begin
      phase_r <= 6'd0;
    end else if (advance) begin
      phase_r <= phase_r + PHASE_STEP;
    end else begin
      phase_r <= phase_r;
    end
  end

  assign sin_val = SIN_LUT[phase_r];
  assign cos_val = SIN_LUT[cos_index(phase_r)];

endmodule

// File: rtl/qpsk_modulator.sv
// Baseband QPSK modulator. Accepts one (I,Q) symbol per valid/ready handshake
// and emits SAMPLES_PER_SYMBOL signed 12-bit carrier samples, one per clock,
// with each component's sign set by its symbol bit. A new symbol is accepted
// on the last-sample cycle so back-to-back symbols stream without a bubble.
// Optional macro QPSK_MOD_CONT_PHASE_EN: keep carrier phase across idle gaps
// (cleared only by reset); otherwise every burst restarts at phase 0.
module qpsk_modulator
  import qpsk_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int PHASE_INC          = 4
) (
  input logic             clk,
  input logic             rst_n,
  qpsk_modulator_if.slave bus
);

  localparam int CNT_W = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sym_i_r;
  logic             sym_q_r;
  logic             valid_r;
  sample_t          out_i_r;
  sample_t          out_q_r;

  logic    ready_s;
  logic    accept_s;
  logic    last_s;
  logic    phase_clr_s;
  sample_t cos_s;
  sample_t sin_s;

  // Handshake decode; ready depends only on registered state.
  always_comb begin
    ready_s  = 1'b0;
    last_s   = 1'b0;
    if (state_r == ST_ACTIVE) begin
      last_s  = (cnt_r == LAST_CNT);
      ready_s = last_s;
    end else begin
      ready_s = 1'b1;
    end
    accept_s = bus.i_valid && ready_s;
  end

`ifdef QPSK_MOD_CONT_PHASE_EN
  assign phase_clr_s = 1'b0;
`else
  assign phase_clr_s = last_s && !accept_s;
`endif

  qpsk_nco #(
    .PHASE_INC (PHASE_INC)
  ) u_nco (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (state_r == ST_ACTIVE),
    .clear   (phase_clr_s),
    .cos_val (cos_s),
    .sin_val (sin_s)
  );

  // Symbol FSM, sample counter and registered sample outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      sym_i_r <= 1'b0;
      sym_q_r <= 1'b0;
      valid_r <= 1'b0;
      out_i_r <= 12'sd0;
      out_q_r <= 12'sd0;
    end else begin
      if (state_r == ST_ACTIVE) begin
        valid_r <= 1'b1;
        out_i_r <= apply_sign(sym_i_r, cos_s);
        out_q_r <= apply_sign(sym_q_r, sin_s);
      end else begin
        valid_r <= 1'b0;
        out_i_r <= 12'sd0;
        out_q_r <= 12'sd0;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r <= ST_ACTIVE;
            cnt_r   <= '0;
            sym_i_r <= bus.i_I;
            sym_q_r <= bus.i_Q;
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (accept_s) begin
            state_r <= ST_ACTIVE;
            cnt_r   <= '0;
            sym_i_r <= bus.i_I;
            sym_q_r <= bus.i_Q;
          end else if (last_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_ACTIVE;
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_valid = valid_r;
  assign bus.o_I     = out_i_r;
  assign bus.o_Q     = out_q_r;

endmodule

// File: tb/tb_qpsk_modulator.sv
// Directed self-checking bench for qpsk_modulator. Main instance uses the
// default parameters; two extra instances cover PHASE_INC=3 (phase carried
// across an idle gap) and PHASE_INC=0 (constant carrier).
module tb_qpsk_modulator;
  import qpsk_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  qpsk_modulator_if bus();
  qpsk_modulator_if bus3();
  qpsk_modulator_if bus0();

  qpsk_modulator #(.SAMPLES_PER_SYMBOL(16), .PHASE_INC(4)) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus.slave));
  qpsk_modulator #(.SAMPLES_PER_SYMBOL(16), .PHASE_INC(3)) dut3 (
    .clk (clk), .rst_n (rst_n), .bus (bus3.slave));
  qpsk_modulator #(.SAMPLES_PER_SYMBOL(16), .PHASE_INC(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  sample_t cap_i [16];
  sample_t cap_q [16];
  int      cap_n;
  int      cap_first;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send one symbol to the idle default instance and capture its samples.
  task automatic run_symbol(input logic si, input logic sq);
    bus.i_I = si;
    bus.i_Q = sq;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("lat_valid_low", bus.o_valid, 0);
    cap_n = 0;
    cap_first = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1 && cap_n < 16) begin
        if (cap_first < 0) cap_first = k;
        cap_i[cap_n] = bus.o_I;
        cap_q[cap_n] = bus.o_Q;
        cap_n++;
      end
    end
    check("sym_valid_count", cap_n, 16);
    check("sym_first_sample", cap_first, 0);
    check("after_valid", bus.o_valid, 0);
    check("after_I", bus.o_I, 0);
    check("after_Q", bus.o_Q, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] word;
    int idx, acc_n, vcnt, first_v, last_v, low_cnt, const_ok;
    int acc_cyc [8];
    logic acc_now;
    logic signed [31:0] exp_i;

    bus.i_I = 1'b0;  bus.i_Q = 1'b0;  bus.i_valid = 1'b0;
    bus3.i_I = 1'b0; bus3.i_Q = 1'b0; bus3.i_valid = 1'b0;
    bus0.i_I = 1'b0; bus0.i_Q = 1'b0; bus0.i_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // 1. Reset values
    check("rst_o_I", bus.o_I, 0);
    check("rst_o_Q", bus.o_Q, 0);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_ready", bus.o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 2. Single symbol I=1,Q=1
    run_symbol(1'b1, 1'b1);
    check("s11_0_I", cap_i[0], 2047);   check("s11_0_Q", cap_q[0], 0);
    check("s11_1_I", cap_i[1], 1891);   check("s11_1_Q", cap_q[1], 783);
    check("s11_2_I", cap_i[2], 1447);   check("s11_2_Q", cap_q[2], 1447);
    check("s11_4_I", cap_i[4], 0);      check("s11_4_Q", cap_q[4], 2047);
    check("s11_8_I", cap_i[8], -2047);  check("s11_8_Q", cap_q[8], 0);
    check("s11_15_I", cap_i[15], 1891); check("s11_15_Q", cap_q[15], -783);

    // 3. Single symbol I=0,Q=1
    run_symbol(1'b0, 1'b1);
    check("s01_0_I", cap_i[0], -2047);  check("s01_0_Q", cap_q[0], 0);
    check("s01_4_I", cap_i[4], 0);      check("s01_4_Q", cap_q[4], 2047);

    // 4. Streamed word, LSB first, i_valid held high
    word = 16'b1110100101111000;
    idx = 0; acc_n = 0; vcnt = 0; first_v = -1; last_v = -1;
    bus.i_I = word[0]; bus.i_Q = word[1]; bus.i_valid = 1'b1;
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (bus.o_valid === 1'b1) begin
        if ((vcnt % 16) == 0 && (vcnt / 16) < 8) begin
          exp_i = word[2 * (vcnt / 16)] ? 2047 : -2047;
          check("stream_s0_I", bus.o_I, exp_i);
          check("stream_s0_Q", bus.o_Q, 0);
        end
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        vcnt++;
      end
      acc_now = bus.i_valid && bus.o_ready;
      if (acc_now) begin
        if (acc_n < 8) acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      @(negedge clk);
      if (acc_now) begin
        idx++;
        if (idx < 8) begin
          bus.i_I = word[2 * idx];
          bus.i_Q = word[2 * idx + 1];
        end else begin
          bus.i_valid = 1'b0;
        end
      end
    end
    check("stream_accepts", acc_n, 8);
    for (int k = 1; k < 8; k++) check("ready_period", acc_cyc[k] - acc_cyc[k-1], 16);
    check("stream_valid_cycles", vcnt, 128);
    check("stream_valid_span", last_v - first_v + 1, 128);

    // 5. Backpressure: B held on i_valid while A plays out
    bus.i_I = 1'b1; bus.i_Q = 1'b0; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_I = 1'b0; bus.i_Q = 1'b1;
    low_cnt = 0;
    for (int g = 0; g < 40 && bus.o_ready !== 1'b1; g++) begin
      low_cnt++;
      @(negedge clk);
    end
    check("bp_ready_low_cycles", low_cnt, 15);
    check("bp_s14_I", bus.o_I, 1447);
    check("bp_s14_Q", bus.o_Q, 1447);
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("bp_s15_valid", bus.o_valid, 1);
    check("bp_s15_I", bus.o_I, 1891);
    check("bp_s15_Q", bus.o_Q, 783);
    @(negedge clk);
    check("bp_B0_valid", bus.o_valid, 1);
    check("bp_B0_I", bus.o_I, -2047);
    check("bp_B0_Q", bus.o_Q, 0);
    check("bp_B0_ready", bus.o_ready, 0);
    repeat (20) @(negedge clk);

    // 1b. Reset asserted mid-symbol
    bus.i_I = 1'b1; bus.i_Q = 1'b1; bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_valid_before", bus.o_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_valid, 0);
    check("mid_rst_I", bus.o_I, 0);
    check("mid_rst_Q", bus.o_Q, 0);
    check("mid_rst_ready", bus.o_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_symbol(1'b1, 1'b1);
    check("post_rst_0_I", cap_i[0], 2047);
    check("post_rst_1_I", cap_i[1], 1891);
    check("post_rst_1_Q", cap_q[1], 783);

    // 6a. Idle gap on the default instance: burst always restarts at COS[0]
    repeat (3) @(negedge clk);
    run_symbol(1'b1, 1'b1);
    check("gap_def_0_I", cap_i[0], 2047);

    // 6b. PHASE_INC=3, three idle cycles between two I=1,Q=1 symbols
    bus3.i_I = 1'b1; bus3.i_Q = 1'b1; bus3.i_valid = 1'b1;
    @(negedge clk);
    bus3.i_valid = 1'b0;
    @(negedge clk);
    check("p3_s0_I", bus3.o_I, 2047);
    check("p3_s0_Q", bus3.o_Q, 0);
    @(negedge clk);
    check("p3_s1_I", bus3.o_I, 1959);
    check("p3_s1_Q", bus3.o_Q, 594);
    repeat (14) @(negedge clk);
    check("p3_s15_valid", bus3.o_valid, 1);
    @(negedge clk);
    check("p3_gap1_valid", bus3.o_valid, 0);
    @(negedge clk);
    bus3.i_valid = 1'b1;
    @(negedge clk);
    bus3.i_valid = 1'b0;
    check("p3_gap3_valid", bus3.o_valid, 0);
    @(negedge clk);
`ifdef QPSK_MOD_CONT_PHASE_EN
    check("p3_second_s0_I", bus3.o_I, 0);
    check("p3_second_s0_Q", bus3.o_Q, -2047);
`else
    check("p3_second_s0_I", bus3.o_I, 2047);
    check("p3_second_s0_Q", bus3.o_Q, 0);
`endif

    // PHASE_INC=0: constant -2047 on I and 0 on Q for I=0,Q=1
    bus0.i_I = 1'b0; bus0.i_Q = 1'b1; bus0.i_valid = 1'b1;
    @(negedge clk);
    bus0.i_valid = 1'b0;
    const_ok = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (bus0.o_valid === 1'b1 && bus0.o_I === -12'sd2047 && bus0.o_Q === 12'sd0)
        const_ok++;
    end
    check("p0_const_samples", const_ok, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
